// File: rtl/gray_sweep_ctrl.sv
// Range sweeper: walks a binary index through [lo, hi] in either direction and
// presents each index as a Gray code word on a valid/ready stream.
module gray_sweep_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir_up,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] g_out,
  output logic [W-1:0] b_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] end_q, end_d;
  logic         dir_q, dir_d;
  logic         err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    end_d     = end_q;
    dir_d     = dir_q;
    err_d     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            dir_d   = dir_up;
            cnt_d   = dir_up ? lo : hi;
            end_d   = dir_up ? hi : lo;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // abort beats a simultaneous handshake: the presented word is dropped
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (cnt_q == end_q) begin
            state_d = S_FIN;
          end else begin
            cnt_d = dir_q ? (cnt_q + ONE) : (cnt_q - ONE);
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err   = err_q;
  assign b_out = cnt_q;
  assign g_out = cnt_q ^ (cnt_q >> 1);

endmodule
